// File: rtl/word_aligner_pkg.sv
// Shared types and sizing helpers for the word aligner.
package word_aligner_pkg;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} align_state_t;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/funnel_shifter.sv
// Combinational funnel shifter: selects W bits from a 2W-bit window at a bit offset.
module funnel_shifter #(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic [2*W-1:0] din,
  input  logic [SW-1:0]  shamt,
  output logic [W-1:0]   dout
);

  logic [2*W-1:0] stage [SW+1];

  assign stage[0] = din;

  // Stage i shifts by 2**i when bit i of the offset is set.
  for (genvar i = 0; i < SW; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? (stage[i] >> (1 << i)) : stage[i];
  end

  assign dout = stage[SW][W-1:0];

endmodule

// File: rtl/word_aligner.sv
// Receive word aligner: hunts the bit offset of a periodic sync word, verifies it,
// then emits aligned words with a start-of-frame flag until the sync is lost.
module word_aligner
  import word_aligner_pkg::*;
#(
  parameter int             W         = 32,
  parameter logic [W-1:0]   SYNC      = 32'h1ACF_FC1D,
  parameter int             FRAME_LEN = 8,
  parameter int             N_LOCK    = 3,
  parameter int             N_UNLOCK  = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  output logic [W-1:0]         dout,
  output logic                 dout_valid,
  output logic                 dout_sof,
  output logic                 locked,
  output logic [$clog2(W)-1:0] offset
);

  localparam int OW = $clog2(W);
  localparam int PW = cnt_w(FRAME_LEN);
  localparam int GW = cnt_w(N_LOCK + 1);
  localparam int MW = cnt_w(N_UNLOCK + 1);

  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(N_LOCK);
  localparam logic [MW-1:0] MISS_DROP = MW'(N_UNLOCK);

  // din_valid qualifies din with no back-pressure: every valid word is consumed on
  // the edge it is presented, and nothing advances while din_valid is low.
  align_state_t  state_q, state_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          primed_q, primed_d;
  logic [PW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [OW-1:0] offset_q, offset_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_sof_q, dout_sof_d;

  logic [W-1:0]  aligned;
  logic          match;
  logic          pos_wrap;

  funnel_shifter #(.W(W)) u_shift (
    .din   ({din, prev_q}),
    .shamt (offset_q),
    .dout  (aligned)
  );

  assign match    = (aligned == SYNC);
  assign pos_wrap = (pos_q == POS_LAST);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    primed_d     = primed_q;
    dwell_d      = dwell_q;
    pos_d        = pos_q;
    good_d       = good_q;
    miss_d       = miss_q;
    offset_d     = offset_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_sof_d   = 1'b0;

    if (din_valid) begin
      prev_d = din;
      if (!primed_q) begin
        // First word only fills the funnel window.
        primed_d = 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            if (match) begin
              state_d = VERIFY;
              pos_d   = '0;
              good_d  = GW'(1);
            end else if (dwell_q == POS_LAST) begin
              offset_d = offset_q + OW'(1);
              dwell_d  = '0;
            end else begin
              dwell_d = dwell_q + PW'(1);
            end
          end
          VERIFY: begin
            pos_d = pos_wrap ? '0 : pos_q + PW'(1);
            if (pos_wrap) begin
              if (!match) begin
                state_d  = SEARCH;
                offset_d = offset_q + OW'(1);
                dwell_d  = '0;
              end else if (good_q + GW'(1) == GOOD_LOCK) begin
                state_d = LOCKED;
                miss_d  = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end
          end
          LOCKED: begin
            pos_d        = pos_wrap ? '0 : pos_q + PW'(1);
            dout_d       = aligned;
            dout_valid_d = 1'b1;
            dout_sof_d   = pos_wrap;
            if (pos_wrap) begin
              if (match) begin
                miss_d = '0;
              end else if (miss_q + MW'(1) == MISS_DROP) begin
                // Lock lost: keep the offset, the stream may recover in place.
                state_d      = SEARCH;
                dwell_d      = '0;
                miss_d       = '0;
                dout_valid_d = 1'b0;
                dout_sof_d   = 1'b0;
              end else begin
                miss_d = miss_q + MW'(1);
              end
            end
          end
          default: begin
            state_d = SEARCH;
            dwell_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= SEARCH;
      prev_q       <= '0;
      primed_q     <= 1'b0;
      dwell_q      <= '0;
      pos_q        <= '0;
      good_q       <= '0;
      miss_q       <= '0;
      offset_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      primed_q     <= primed_d;
      dwell_q      <= dwell_d;
      pos_q        <= pos_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      offset_q     <= offset_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign locked     = (state_q == LOCKED);
  assign offset     = offset_q;

endmodule
